// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: two-read/one-write register file with write bypass, optional zero register and sequenced clear
// Ports: clk_i clock; reset_i synchronous active-high reset (starts a clear sweep);
// wr_en_i/wr_addr_i/wr_data_i write port; rd{0,1}_en_i/rd{0,1}_addr_i read requests;
// rd{0,1}_data_o registered read data; clr_req_i starts a one-entry-per-cycle clear;
// busy_o clear sweep in progress; wr_err_o one-cycle pulse when a write was dropped during a sweep.
module reg_file_2r1w #(
    parameter int DATA_W   = 20,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd0_en_i,
    input  logic [ADDR_W-1:0] rd0_addr_i,
    output logic [DATA_W-1:0] rd0_data_o,
    input  logic              rd1_en_i,
    input  logic [ADDR_W-1:0] rd1_addr_i,
    output logic [DATA_W-1:0] rd1_data_o,
    input  logic              clr_req_i,
    output logic              busy_o,
    output logic              wr_err_o
);
    localparam int DEPTH = 2**ADDR_W;
    typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd0_data_q, rd0_data_d, rd1_data_q, rd1_data_d;
    logic              wr_err_q, wr_err_d, wr_ok, last_idx;

    assign busy_o     = state_q == CLEAR;
    assign last_idx   = clr_idx_q == ADDR_W'(DEPTH - 1);
    // A write lands only in IDLE and never into a hard-wired zero entry.
    assign wr_ok      = wr_en_i && !busy_o && !(ZERO_REG != 0 && wr_addr_i == '0);
    assign rd0_data_o = rd0_data_q;
    assign rd1_data_o = rd1_data_q;
    assign wr_err_o   = wr_err_q;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (busy_o) begin
            state_d   = last_idx ? IDLE : CLEAR;
            clr_idx_d = last_idx ? '0 : clr_idx_q + 1'b1;
        end else if (clr_req_i) begin
            state_d   = CLEAR;
            clr_idx_d = '0;
        end
        wr_err_d   = wr_en_i && busy_o;
        rd0_data_d = !rd0_en_i ? rd0_data_q :
                     (busy_o || (ZERO_REG != 0 && rd0_addr_i == '0)) ? '0 :
                     (BYPASS != 0 && wr_ok && wr_addr_i == rd0_addr_i) ? wr_data_i : mem_q[rd0_addr_i];
        rd1_data_d = !rd1_en_i ? rd1_data_q :
                     (busy_o || (ZERO_REG != 0 && rd1_addr_i == '0)) ? '0 :
                     (BYPASS != 0 && wr_ok && wr_addr_i == rd1_addr_i) ? wr_data_i : mem_q[rd1_addr_i];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= CLEAR;
            clr_idx_q  <= '0;
            rd0_data_q <= '0;
            rd1_data_q <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            rd0_data_q <= rd0_data_d;
            rd1_data_q <= rd1_data_d;
            wr_err_q   <= wr_err_d;
        end
    end

    // Storage has no reset so it can map to distributed RAM; the sweep zeros it instead.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (busy_o)
                mem_q[clr_idx_q] <= '0;
            else if (wr_ok)
                mem_q[wr_addr_i] <= wr_data_i;
        end
    end
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: table and sequence checks of two reg_file_2r1w instances (defaults, and ZERO_REG=1/BYPASS=0)
module tb_reg_file_2r1w;
    logic        clk = 1'b0;
    logic        rst, we, r0, r1, clr;
    logic [3:0]  wa, a0, a1;
    logic [19:0] wd;
    logic [19:0] a_rd0, a_rd1, b_rd0, b_rd1;
    logic        a_busy, b_busy, a_err, b_err;

    always #5 clk = ~clk;

    reg_file_2r1w u_a (
        .clk_i(clk), .reset_i(rst), .wr_en_i(we), .wr_addr_i(wa), .wr_data_i(wd),
        .rd0_en_i(r0), .rd0_addr_i(a0), .rd0_data_o(a_rd0),
        .rd1_en_i(r1), .rd1_addr_i(a1), .rd1_data_o(a_rd1),
        .clr_req_i(clr), .busy_o(a_busy), .wr_err_o(a_err)
    );

    reg_file_2r1w #(.ZERO_REG(1), .BYPASS(0)) u_b (
        .clk_i(clk), .reset_i(rst), .wr_en_i(we), .wr_addr_i(wa), .wr_data_i(wd),
        .rd0_en_i(r0), .rd0_addr_i(a0), .rd0_data_o(b_rd0),
        .rd1_en_i(r1), .rd1_addr_i(a1), .rd1_data_o(b_rd1),
        .clr_req_i(clr), .busy_o(b_busy), .wr_err_o(b_err)
    );

    typedef struct {
        logic        rst, clr, we;
        logic [3:0]  wa;
        logic [19:0] wd;
        logic        r0;
        logic [3:0]  a0;
        logic        r1;
        logic [3:0]  a1;
        logic [19:0] ea0, ea1, eb0, eb1;
        logic        ebusy, eerr;
    } vec_t;

    typedef struct {
        string       tag;
        logic [19:0] ea0, ea1, eb0, eb1;
        logic        ebusy, eerr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t rv(logic w, logic [3:0] wadr, logic [19:0] wdat,
                                logic e0, logic [3:0] ad0, logic e1, logic [3:0] ad1,
                                logic [19:0] xa0, logic [19:0] xa1, logic [19:0] xb0, logic [19:0] xb1);
        vec_t v;
        v.rst = 1'b0; v.clr = 1'b0; v.we = w; v.wa = wadr; v.wd = wdat;
        v.r0 = e0; v.a0 = ad0; v.r1 = e1; v.a1 = ad1;
        v.ea0 = xa0; v.ea1 = xa1; v.eb0 = xb0; v.eb1 = xb1;
        v.ebusy = 1'b0; v.eerr = 1'b0;
        return v;
    endfunction

    task automatic chk(string name, logic [19:0] act, logic [19:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(string tag, vec_t v);
        exp_t e;
        rst = v.rst; clr = v.clr; we = v.we; wa = v.wa; wd = v.wd;
        r0 = v.r0; a0 = v.a0; r1 = v.r1; a1 = v.a1;
        e.tag = tag; e.ea0 = v.ea0; e.ea1 = v.ea1; e.eb0 = v.eb0; e.eb1 = v.eb1;
        e.ebusy = v.ebusy; e.eerr = v.eerr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, " a.rd0"}, a_rd0, e.ea0);
        chk({e.tag, " a.rd1"}, a_rd1, e.ea1);
        chk({e.tag, " b.rd0"}, b_rd0, e.eb0);
        chk({e.tag, " b.rd1"}, b_rd1, e.eb1);
        chk({e.tag, " a.busy"}, 20'(a_busy), 20'(e.ebusy));
        chk({e.tag, " b.busy"}, 20'(b_busy), 20'(e.ebusy));
        chk({e.tag, " a.wr_err"}, 20'(a_err), 20'(e.eerr));
        chk({e.tag, " b.wr_err"}, 20'(b_err), 20'(e.eerr));
    endtask

    initial begin
        vec_t tbl[11];
        vec_t v;
        rst = 1'b1; clr = 1'b0; we = 1'b0; wa = '0; wd = '0;
        r0 = 1'b0; a0 = '0; r1 = 1'b0; a1 = '0;

        // write-then-read, bypass vs. old value, zero register, read hold
        tbl[0]  = rv(1, 4'd5, 20'hABCDE, 0, 4'd0, 0, 4'd0, 20'h00000, 20'h00000, 20'h00000, 20'h00000);
        tbl[1]  = rv(0, 4'd0, 20'h00000, 1, 4'd5, 1, 4'd6, 20'hABCDE, 20'h00000, 20'hABCDE, 20'h00000);
        tbl[2]  = rv(1, 4'd3, 20'h11111, 0, 4'd0, 0, 4'd0, 20'hABCDE, 20'h00000, 20'hABCDE, 20'h00000);
        tbl[3]  = rv(1, 4'd3, 20'h12345, 1, 4'd3, 1, 4'd3, 20'h12345, 20'h12345, 20'h11111, 20'h11111);
        tbl[4]  = rv(0, 4'd0, 20'h00000, 1, 4'd3, 1, 4'd5, 20'h12345, 20'hABCDE, 20'h12345, 20'hABCDE);
        tbl[5]  = rv(1, 4'd0, 20'hFFFFF, 0, 4'd0, 0, 4'd0, 20'h12345, 20'hABCDE, 20'h12345, 20'hABCDE);
        tbl[6]  = rv(0, 4'd0, 20'h00000, 1, 4'd0, 1, 4'd1, 20'hFFFFF, 20'h00000, 20'h00000, 20'h00000);
        tbl[7]  = rv(1, 4'd1, 20'h77777, 1, 4'd0, 1, 4'd1, 20'hFFFFF, 20'h77777, 20'h00000, 20'h00000);
        tbl[8]  = rv(0, 4'd0, 20'h00000, 0, 4'd9, 1, 4'd1, 20'hFFFFF, 20'h77777, 20'h00000, 20'h77777);
        tbl[9]  = rv(1, 4'd0, 20'h22222, 1, 4'd0, 0, 4'd2, 20'h22222, 20'h77777, 20'h00000, 20'h77777);
        tbl[10] = rv(0, 4'd0, 20'h00000, 0, 4'd0, 1, 4'd0, 20'h22222, 20'h22222, 20'h00000, 20'h00000);

        // reset, then the initial sweep must last exactly 16 cycles
        v = rv(0, 4'd0, 20'h0, 0, 4'd0, 0, 4'd0, 20'h0, 20'h0, 20'h0, 20'h0);
        v.rst = 1'b1; v.ebusy = 1'b1;
        step("reset", v);
        for (int i = 0; i < 16; i++) begin
            v = rv(0, 4'd0, 20'h0, 0, 4'd0, 0, 4'd0, 20'h0, 20'h0, 20'h0, 20'h0);
            v.ebusy = i < 15;
            step($sformatf("init_sweep%0d", i), v);
        end
        for (int i = 0; i < 16; i++)
            step($sformatf("init_rd%0d", i),
                 rv(0, 4'd0, 20'h0, 1, 4'(i), 1, 4'(15 - i), 20'h0, 20'h0, 20'h0, 20'h0));

        for (int i = 0; i < 11; i++)
            step($sformatf("vec%0d", i), tbl[i]);

        // fill, then clear with clr_req held through the first sweep cycles and a write dropped on the third
        for (int i = 0; i < 16; i++)
            step($sformatf("fill%0d", i),
                 rv(1, 4'(i), 20'h5A5A5, 0, 4'd0, 0, 4'd0, 20'h22222, 20'h22222, 20'h00000, 20'h00000));
        step("fill_rd", rv(0, 4'd0, 20'h0, 1, 4'd7, 1, 4'd0, 20'h5A5A5, 20'h5A5A5, 20'h5A5A5, 20'h00000));
        v = rv(0, 4'd0, 20'h0, 0, 4'd0, 0, 4'd0, 20'h5A5A5, 20'h5A5A5, 20'h5A5A5, 20'h00000);
        v.clr = 1'b1; v.ebusy = 1'b1;
        step("clr_req", v);
        for (int i = 0; i < 16; i++) begin
            v = rv(i == 2, 4'd7, 20'h0F0F0, 1, 4'd7, 1, 4'd2, 20'h0, 20'h0, 20'h0, 20'h0);
            v.clr = i < 3; v.ebusy = i < 15; v.eerr = i == 2;
            step($sformatf("clr_sweep%0d", i), v);
        end
        for (int i = 0; i < 16; i++)
            step($sformatf("post_clr_rd%0d", i),
                 rv(0, 4'd0, 20'h0, 1, 4'(i), 1, 4'(15 - i), 20'h0, 20'h0, 20'h0, 20'h0));

        // reset at sweep index 9 restarts a full sweep and zeros the read registers
        step("pre_wr", rv(1, 4'd4, 20'h33333, 0, 4'd0, 0, 4'd0, 20'h0, 20'h0, 20'h0, 20'h0));
        step("pre_rd", rv(0, 4'd0, 20'h0, 1, 4'd4, 1, 4'd4, 20'h33333, 20'h33333, 20'h33333, 20'h33333));
        v = rv(0, 4'd0, 20'h0, 0, 4'd0, 0, 4'd0, 20'h33333, 20'h33333, 20'h33333, 20'h33333);
        v.clr = 1'b1; v.ebusy = 1'b1;
        step("clr2", v);
        for (int i = 0; i < 9; i++) begin
            v = rv(0, 4'd0, 20'h0, 0, 4'd0, 0, 4'd0, 20'h33333, 20'h33333, 20'h33333, 20'h33333);
            v.ebusy = 1'b1;
            step($sformatf("mid_sweep%0d", i), v);
        end
        v = rv(1, 4'd9, 20'h44444, 1, 4'd4, 1, 4'd4, 20'h0, 20'h0, 20'h0, 20'h0);
        v.rst = 1'b1; v.clr = 1'b1; v.ebusy = 1'b1;
        step("mid_reset", v);
        for (int i = 0; i < 16; i++) begin
            v = rv(0, 4'd0, 20'h0, 0, 4'd0, 0, 4'd0, 20'h0, 20'h0, 20'h0, 20'h0);
            v.ebusy = i < 15;
            step($sformatf("re_sweep%0d", i), v);
        end
        step("final_rd", rv(0, 4'd0, 20'h0, 1, 4'd4, 1, 4'd9, 20'h0, 20'h0, 20'h0, 20'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
